puf_challenge_driver: RTL

//  Initiator side of the arbiter_puf challenge/response interface.
//  - Generates an LFSR challenge sequence and holds each challenge for a settle window.
//  - Samples the PUF response and packs the bits into WORD_W-bit words.
//  - Streams the words out over a valid/ready handshake.
//  - Sits between the control logic and an arbiter_puf instance; feeds enrollment and auth paths.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/puf_lfsr.sv | 19 +
 rtl/puf_challenge_driver.sv | 89 ++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared types, LFSR tap table and step function for the arbiter PUF challenge paths
//   state_t   : driver FSM states
//   TAPS[n]   : maximal-length feedback taps for an n-bit LFSR, n = 4..32
//   lfsr_next : one shift-left step of an n-bit LFSR held in the low bits of a 32-bit word
package puf_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EMIT, DONE} state_t;
  localparam logic [31:0] TAPS [4:32] = '{
    32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060, 32'h0000_00B8,
    32'h0000_0110, 32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
    32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
    32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
    32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013, 32'h0900_0000,
    32'h1400_0000, 32'h2000_0029, 32'h4800_0000, 32'h8020_0003
  };
  function automatic logic [31:0] lfsr_next(input logic [31:0] lfsr, input int n);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF >> (32 - n);
    return ((lfsr << 1) | {31'd0, ^(lfsr & TAPS[n])}) & mask;
  endfunction
endpackage

// File: rtl/puf_lfsr.sv
// puf_lfsr: loadable N-bit challenge LFSR (clk, rst active-low sync, load/step controls, seed in, value out)
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] seed,
  output logic [N-1:0] value
);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk)
    if (!rst) value <= '0;
    else if (load) value <= seed == '0 ? N'(1) : seed;
    else if (step) value <= N'(lfsr_next(32'(value), N));
endmodule

// File: rtl/puf_challenge_driver.sv
// puf_challenge_driver: drives LFSR challenges to an arbiter PUF, packs sampled responses into words, streams them out
//   control : clk, rst (sync, active-low), start, seed[N], num_words[16] -> busy, done
//   puf     : challenge[N] out, response[M] in
//   stream  : word_data[WORD_W], word_valid out, word_ready in
module puf_challenge_driver
  import puf_pkg::*;
#(
  parameter int N          = 4,
  parameter int M          = 1,
  parameter int WORD_W     = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      seed,
  input  logic [15:0]       num_words,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      challenge,
  input  logic [M-1:0]      response,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready
);
  localparam int BITS = WORD_W / M;
  localparam int CW   = $clog2(SETTLE_CYC + 1);
  localparam int BW   = BITS > 1 ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [15:0] words_left;
  logic load, last_bit;
  assign load       = state == IDLE && start && num_words != 16'd0;
  assign last_bit   = bit_idx == BW'(BITS - 1);
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign word_valid = state == EMIT;
  puf_lfsr #(.N(N)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (state == SAMPLE),
    .seed (seed),
    .value(challenge)
  );
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (num_words != 16'd0 ? SETTLE : DONE) : IDLE;
      SETTLE:  state_n = cnt == '0 ? SAMPLE : SETTLE;
      SAMPLE:  state_n = last_bit ? EMIT : SETTLE;
      EMIT:    state_n = word_ready ? (words_left == 16'd1 ? DONE : SETTLE) : EMIT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // While stalled in EMIT nothing here moves, so word_data and the challenge stay put.
  always_ff @(posedge clk)
    if (!rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      words_left <= '0;
      word_data  <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          words_left <= num_words;
          bit_idx    <= '0;
          cnt        <= RELOAD;
        end
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE: begin
          word_data[bit_idx*M +: M] <= response;
          bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
          cnt     <= RELOAD;
        end
        EMIT: if (word_ready) begin
          words_left <= words_left - 16'd1;
          cnt        <= RELOAD;
        end
        default: ;
      endcase
    end
endmodule
